// File: rtl/hazard3_ifetch_ahbl.sv
// hazard3_ifetch_ahbl: instruction-fetch adapter from the core frontend's
// decoupled fetch interface to a single read-only AHB-Lite master port.
// The address phase is a combinational pass-through. A small state machine
// tracks the single outstanding data phase and the two-cycle error response.
// Optional feature macro: HAZARD3_IFETCH_ERR_CANCEL_EN. When it is defined, the
// address phase is suppressed during the first error cycle.
module hazard3_ifetch_ahbl #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              mem_size,
    input  logic [W_ADDR-1:0] mem_addr,
    input  logic              mem_addr_vld,
    output logic              mem_addr_rdy,
    output logic [W_DATA-1:0] mem_data,
    output logic              mem_data_vld,
    output logic              mem_data_err,
    input  logic              priv_m,
    output logic [W_ADDR-1:0] err_addr,

    output logic [W_ADDR-1:0] ahbl_haddr,
    output logic [1:0]        ahbl_htrans,
    output logic [2:0]        ahbl_hsize,
    output logic              ahbl_hwrite,
    output logic              ahbl_hmastlock,
    output logic [2:0]        ahbl_hburst,
    output logic [3:0]        ahbl_hprot,
    input  logic              ahbl_hready,
    input  logic              ahbl_hresp,
    input  logic [W_DATA-1:0] ahbl_hrdata
);

    typedef enum logic [1:0] {
        IDLE_DPH = 2'b00,
        DPH      = 2'b01,
        ERR1     = 2'b10
    } dph_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    dph_state_t        state_r;
    dph_state_t        state_nxt_s;
    logic [W_ADDR-1:0] dph_addr_r;
    logic [W_ADDR-1:0] err_addr_r;
    logic              err_first_s;
    logic              addr_accept_s;
    logic              data_vld_s;
    logic              data_err_s;

`ifdef HAZARD3_IFETCH_ERR_CANCEL_EN
    // First cycle of an error response: the pending address phase must be
    // withdrawn. The frontend keeps holding it, so it reappears next cycle.
    assign err_first_s = (state_r == DPH) && !ahbl_hready && ahbl_hresp;
`else
    assign err_first_s = 1'b0;
`endif

    // Address phase: straight pass-through, suppressed during reset and
    // (optionally) during the first error cycle.
    assign mem_addr_rdy   = rst_n && mem_addr_vld && ahbl_hready && !err_first_s;
    assign addr_accept_s  = mem_addr_rdy;
    assign ahbl_htrans    = (rst_n && mem_addr_vld && !err_first_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahbl_haddr     = mem_addr;
    assign ahbl_hsize     = mem_size ? 3'b010 : 3'b001;
    assign ahbl_hwrite    = 1'b0;
    assign ahbl_hmastlock = 1'b0;
    assign ahbl_hburst    = 3'b000;
    assign ahbl_hprot     = {2'b00, priv_m, 1'b0};

    // Halfword data is returned unsteered; the frontend picks the half.
    assign mem_data     = ahbl_hrdata;
    assign mem_data_vld = data_vld_s;
    assign mem_data_err = data_err_s;
    assign err_addr     = err_addr_r;

    // Data-phase next state and the zero-latency data-return strobes.
    always_comb begin
        state_nxt_s = state_r;
        data_vld_s  = 1'b0;
        data_err_s  = 1'b0;
        if (!rst_n) begin
            state_nxt_s = IDLE_DPH;
        end else begin
            case (state_r)
                IDLE_DPH: begin
                    // A stray hresp with nothing outstanding is ignored.
                    if (addr_accept_s) begin
                        state_nxt_s = DPH;
                    end else begin
                        state_nxt_s = IDLE_DPH;
                    end
                end
                DPH: begin
                    if (ahbl_hready) begin
                        data_vld_s  = 1'b1;
                        state_nxt_s = addr_accept_s ? DPH : IDLE_DPH;
                    end else if (ahbl_hresp) begin
                        state_nxt_s = ERR1;
                    end else begin
                        state_nxt_s = DPH;
                    end
                end
                ERR1: begin
                    // hready low here is a slave protocol violation; wait it out.
                    if (ahbl_hready) begin
                        data_vld_s  = 1'b1;
                        data_err_s  = 1'b1;
                        state_nxt_s = addr_accept_s ? DPH : IDLE_DPH;
                    end else begin
                        state_nxt_s = ERR1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE_DPH;
                end
            endcase
        end
    end

    // State register, data-phase address capture and fault address latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE_DPH;
            dph_addr_r <= {W_ADDR{1'b0}};
            err_addr_r <= {W_ADDR{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (addr_accept_s) begin
                dph_addr_r <= mem_addr;
            end
            if ((state_r == ERR1) && ahbl_hready) begin
                err_addr_r <= dph_addr_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard3_ifetch_ahbl.sv
// Self-checking bench for hazard3_ifetch_ahbl: table of per-cycle vectors
// plus a hand-written error-response and reset sequence.
module tb_hazard3_ifetch_ahbl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_size;
    logic [31:0] mem_addr;
    logic        mem_addr_vld;
    logic        mem_addr_rdy;
    logic [31:0] mem_data;
    logic        mem_data_vld;
    logic        mem_data_err;
    logic        priv_m;
    logic [31:0] err_addr;
    logic [31:0] ahbl_haddr;
    logic [1:0]  ahbl_htrans;
    logic [2:0]  ahbl_hsize;
    logic        ahbl_hwrite;
    logic        ahbl_hmastlock;
    logic [2:0]  ahbl_hburst;
    logic [3:0]  ahbl_hprot;
    logic        ahbl_hready;
    logic        ahbl_hresp;
    logic [31:0] ahbl_hrdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard3_ifetch_ahbl #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_addr_vld   (mem_addr_vld),
        .mem_addr_rdy   (mem_addr_rdy),
        .mem_data       (mem_data),
        .mem_data_vld   (mem_data_vld),
        .mem_data_err   (mem_data_err),
        .priv_m         (priv_m),
        .err_addr       (err_addr),
        .ahbl_haddr     (ahbl_haddr),
        .ahbl_htrans    (ahbl_htrans),
        .ahbl_hsize     (ahbl_hsize),
        .ahbl_hwrite    (ahbl_hwrite),
        .ahbl_hmastlock (ahbl_hmastlock),
        .ahbl_hburst    (ahbl_hburst),
        .ahbl_hprot     (ahbl_hprot),
        .ahbl_hready    (ahbl_hready),
        .ahbl_hresp     (ahbl_hresp),
        .ahbl_hrdata    (ahbl_hrdata)
    );

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic        size;
        logic [31:0] addr;
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic        e_rdy;
        logic [1:0]  e_htrans;
        logic [2:0]  e_hsize;
        logic        e_dvld;
        logic        e_derr;
        logic [31:0] e_err_addr;
    } vec_t;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [2:0] HW = 3'b010;
    localparam logic [2:0] HH = 3'b001;
`ifdef HAZARD3_IFETCH_ERR_CANCEL_EN
    localparam logic [1:0] ERR_FIRST_HTRANS = 2'b00;
`else
    localparam logic [1:0] ERR_FIRST_HTRANS = 2'b10;
`endif

    vec_t tbl [14];
    vec_t seq [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check outputs before the rising edge.
    task automatic apply(input string tag, input int idx, input vec_t v);
        logic p;
        @(negedge clk);
        p            = idx[0];
        rst_n        = v.rst_n;
        mem_addr_vld = v.vld;
        mem_size     = v.size;
        mem_addr     = v.addr;
        ahbl_hready  = v.hready;
        ahbl_hresp   = v.hresp;
        ahbl_hrdata  = v.hrdata;
        priv_m       = p;
        #2;
        chk($sformatf("%s[%0d].rdy", tag, idx),    {31'd0, mem_addr_rdy}, {31'd0, v.e_rdy});
        chk($sformatf("%s[%0d].htrans", tag, idx), {30'd0, ahbl_htrans},  {30'd0, v.e_htrans});
        chk($sformatf("%s[%0d].haddr", tag, idx),  ahbl_haddr,            v.addr);
        chk($sformatf("%s[%0d].hsize", tag, idx),  {29'd0, ahbl_hsize},   {29'd0, v.e_hsize});
        chk($sformatf("%s[%0d].dvld", tag, idx),   {31'd0, mem_data_vld}, {31'd0, v.e_dvld});
        chk($sformatf("%s[%0d].derr", tag, idx),   {31'd0, mem_data_err}, {31'd0, v.e_derr});
        chk($sformatf("%s[%0d].err_addr", tag, idx), err_addr,            v.e_err_addr);
        chk($sformatf("%s[%0d].hprot", tag, idx),  {28'd0, ahbl_hprot},   {28'd0, 2'b00, p, 1'b0});
        if (v.e_dvld) begin
            chk($sformatf("%s[%0d].data", tag, idx), mem_data, v.hrdata);
        end
    endtask

    initial begin
        //            rst vld sz addr          rdy hres hrdata        e_rdy htrans hsize dvld derr err_addr
        tbl[0]  = '{1'b0,1'b1,1'b1,32'h0000_0000,1'b1,1'b0,32'h0,         1'b0,ID,HW,1'b0,1'b0,32'h0};
        tbl[1]  = '{1'b1,1'b1,1'b1,32'h0000_0000,1'b1,1'b0,32'hDEAD_BEEF, 1'b1,NS,HW,1'b0,1'b0,32'h0};
        tbl[2]  = '{1'b1,1'b1,1'b1,32'h0000_0004,1'b1,1'b0,32'h1111_1111, 1'b1,NS,HW,1'b1,1'b0,32'h0};
        tbl[3]  = '{1'b1,1'b1,1'b1,32'h0000_0008,1'b1,1'b0,32'h2222_2222, 1'b1,NS,HW,1'b1,1'b0,32'h0};
        tbl[4]  = '{1'b1,1'b0,1'b1,32'h0000_000C,1'b1,1'b0,32'h3333_3333, 1'b0,ID,HW,1'b1,1'b0,32'h0};
        tbl[5]  = '{1'b1,1'b0,1'b1,32'h0000_000C,1'b1,1'b0,32'h9999_9999, 1'b0,ID,HW,1'b0,1'b0,32'h0};
        tbl[6]  = '{1'b1,1'b1,1'b1,32'h0000_0100,1'b1,1'b0,32'h0,         1'b1,NS,HW,1'b0,1'b0,32'h0};
        tbl[7]  = '{1'b1,1'b1,1'b1,32'h0000_0104,1'b0,1'b0,32'h0BAD_0001, 1'b0,NS,HW,1'b0,1'b0,32'h0};
        tbl[8]  = '{1'b1,1'b1,1'b1,32'h0000_0104,1'b0,1'b0,32'h0BAD_0002, 1'b0,NS,HW,1'b0,1'b0,32'h0};
        tbl[9]  = '{1'b1,1'b1,1'b1,32'h0000_0104,1'b1,1'b0,32'h4444_4444, 1'b1,NS,HW,1'b1,1'b0,32'h0};
        tbl[10] = '{1'b1,1'b0,1'b1,32'h0000_0108,1'b1,1'b0,32'h5555_5555, 1'b0,ID,HW,1'b1,1'b0,32'h0};
        tbl[11] = '{1'b1,1'b1,1'b0,32'h0000_0202,1'b1,1'b0,32'h0,         1'b1,NS,HH,1'b0,1'b0,32'h0};
        tbl[12] = '{1'b1,1'b0,1'b0,32'h0000_0204,1'b1,1'b0,32'hABCD_1234, 1'b0,ID,HH,1'b1,1'b0,32'h0};
        tbl[13] = '{1'b1,1'b0,1'b1,32'h0000_0208,1'b1,1'b1,32'h7777_7777, 1'b0,ID,HW,1'b0,1'b0,32'h0};

        // Error response on 0x300 with 0x304 pending, then reset mid-transfer.
        seq[0] = '{1'b1,1'b1,1'b1,32'h0000_0300,1'b1,1'b0,32'h0,         1'b1,NS,HW,1'b0,1'b0,32'h0};
        seq[1] = '{1'b1,1'b1,1'b1,32'h0000_0304,1'b0,1'b1,32'h0,         1'b0,ERR_FIRST_HTRANS,HW,1'b0,1'b0,32'h0};
        seq[2] = '{1'b1,1'b1,1'b1,32'h0000_0304,1'b1,1'b1,32'hEEEE_EEEE, 1'b1,NS,HW,1'b1,1'b1,32'h0};
        seq[3] = '{1'b1,1'b0,1'b1,32'h0000_0308,1'b1,1'b0,32'h6666_6666, 1'b0,ID,HW,1'b1,1'b0,32'h0000_0300};
        seq[4] = '{1'b1,1'b1,1'b1,32'h0000_0400,1'b1,1'b0,32'h0,         1'b1,NS,HW,1'b0,1'b0,32'h0000_0300};
        seq[5] = '{1'b0,1'b1,1'b1,32'h0000_0404,1'b1,1'b0,32'h8888_8888, 1'b0,ID,HW,1'b0,1'b0,32'h0000_0300};
        seq[6] = '{1'b1,1'b0,1'b1,32'h0000_0408,1'b1,1'b0,32'h8888_8888, 1'b0,ID,HW,1'b0,1'b0,32'h0};

        rst_n        = 1'b0;
        mem_addr_vld = 1'b0;
        mem_size     = 1'b1;
        mem_addr     = 32'h0;
        ahbl_hready  = 1'b1;
        ahbl_hresp   = 1'b0;
        ahbl_hrdata  = 32'h0;
        priv_m       = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            apply("tbl", i, tbl[i]);
        end
        chk("tied_zero", {27'd0, ahbl_hwrite, ahbl_hmastlock, ahbl_hburst}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            apply("seq", i, seq[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
